// File: rtl/nn_pkg.sv
// Shared types for the network input path.
// Data format, bank occupancy and serve-FSM states.
package nn_pkg;

  localparam int DW   = 8;
  localparam int FRAC = 4;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    SERVING
  } bank_st_t;

  typedef enum logic {
    IDLE,
    BUSY
  } srv_st_t;

endpackage

// File: rtl/layer_input_server_if.sv
// Producer, layer read and layer start/ack bundle.
// master = producer/layer side, slave = server.
interface layer_input_server_if #(
  parameter int DW = nn_pkg::DW,
  parameter int AW = 1
);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          rd_trig;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          layer_req;
  logic          layer_ack;
  logic [7:0]    vec_count;

  modport master (
    output in_valid, in_data,
    output rd_trig, rd_addr,
    output layer_ack,
    input  in_ready, rd_data, rd_valid,
    input  layer_req, vec_count
  );

  modport slave (
    input  in_valid, in_data,
    input  rd_trig, rd_addr,
    input  layer_ack,
    output in_ready, rd_data, rd_valid,
    output layer_req, vec_count
  );

endinterface

// File: rtl/layer_input_bank.sv
// One N-entry element bank with a write port
// and a registered, range-checked read port.
module layer_input_bank #(
  parameter int DW = 8,
  parameter int AW = 1,
  parameter int N  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // element storage; contents survive release
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  // registered read, addresses past N read as 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (32'(raddr) < N) ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/layer_input_server.sv
// Ping-pong input buffer answering layer0 reads.
// Producer fills one bank while the layer reads the other.
module layer_input_server
  import nn_pkg::*;
#(
  parameter int N  = 2,
  parameter int AW = 1,
  parameter int DW = nn_pkg::DW
) (
  input logic clk,
  input logic rst,
  layer_input_server_if.slave bus
);

  bank_st_t      bst [2];
  srv_st_t       st;
  srv_st_t       st_nx;
  logic          wr_bank;
  logic          srv_bank;
  logic [AW-1:0] wr_idx;
  logic          accept;
  logic          last;
  logic          start;
  logic          rel;
  logic [DW-1:0] q [2];
  logic          sel_q;
  logic          zero_q;
  logic          rv;
  logic [7:0]    vcnt;

  assign bus.in_ready  = (bst[wr_bank] == EMPTY);
  assign accept        = bus.in_valid && bus.in_ready;
  assign last          = accept && (wr_idx == AW'(N - 1));
  assign bus.layer_req = (st == BUSY);
  assign bus.vec_count = vcnt;
  assign bus.rd_valid  = rv;
  assign bus.rd_data   = zero_q ? '0 : q[sel_q];

  // serve FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  // serve FSM next state
  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: if (bst[srv_bank] == FULL) st_nx = BUSY;
      BUSY: if (bus.layer_ack) st_nx = IDLE;
    endcase
  end

  // serve FSM outputs: bank hand-off and release strobes
  always_comb begin
    start = 1'b0;
    rel   = 1'b0;
    unique case (st)
      IDLE: start = (bst[srv_bank] == FULL);
      BUSY: rel   = bus.layer_ack;
    endcase
  end

  // write index, bank ownership and release count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bst[0]   <= EMPTY;
      bst[1]   <= EMPTY;
      wr_bank  <= 1'b0;
      srv_bank <= 1'b0;
      wr_idx   <= '0;
      vcnt     <= '0;
    end else begin
      if (accept) wr_idx <= last ? '0 : wr_idx + 1'b1;
      if (last) begin
        bst[wr_bank] <= FULL;
        wr_bank      <= ~wr_bank;
      end
      if (start) bst[srv_bank] <= SERVING;
      if (rel) begin
        bst[srv_bank] <= EMPTY;
        srv_bank      <= ~srv_bank;
        vcnt          <= vcnt + 8'd1;
      end
    end
  end

  layer_input_bank #(.DW(DW), .AW(AW), .N(N)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && !wr_bank),
    .widx  (wr_idx),
    .wdata (bus.in_data),
    .re    (bus.rd_trig && !srv_bank),
    .raddr (bus.rd_addr),
    .rdata (q[0])
  );

  layer_input_bank #(.DW(DW), .AW(AW), .N(N)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && wr_bank),
    .widx  (wr_idx),
    .wdata (bus.in_data),
    .re    (bus.rd_trig && srv_bank),
    .raddr (bus.rd_addr),
    .rdata (q[1])
  );

  // read response: bank select and not-serving zeroing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv     <= 1'b0;
      sel_q  <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      rv <= bus.rd_trig;
      if (bus.rd_trig) begin
        sel_q  <= srv_bank;
        zero_q <= (bst[srv_bank] != SERVING);
      end
    end
  end

endmodule

// File: tb/tb_layer_input_server.sv
// Scoreboard bench for layer_input_server (N=3, AW=2).
// Vector-level queue model predicts reads, req and count.
module tb_layer_input_server;

  localparam int N  = 3;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  layer_input_server_if #(.DW(8), .AW(AW)) bus ();

  layer_input_server #(.N(N), .AW(AW), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [N*8-1:0] vq [$];
  logic [7:0]     part [$];
  logic [7:0]     cur [2**AW];
  bit             m_req = 1'b0;
  logic [7:0]     m_cnt = 8'd0;
  logic [7:0]     exp_q [$];
  logic [7:0]     last_rd = 8'd0;
  bit             prev_req = 1'b0;
  int             rises = 0;

  function automatic bit m_ready();
    return (vq.size() + int'(m_req)) < 2;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // one clock: drive, advance the model, sample at negedge
  task automatic step(bit iv, logic [7:0] d, bit trig,
                      logic [AW-1:0] a, bit ack, output bit acc);
    bit pend;
    logic [N*8-1:0] v;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.rd_trig   = trig;
    bus.rd_addr   = a;
    bus.layer_ack = ack;
    acc  = iv && m_ready();
    pend = vq.size() > 0;
    if (trig) exp_q.push_back((m_req && int'(a) < N) ? cur[a] : 8'd0);
    if (acc) begin
      part.push_back(d);
      if (part.size() == N) begin
        v = '0;
        for (int i = 0; i < N; i++) v[i*8 +: 8] = part[i];
        vq.push_back(v);
        part.delete();
      end
    end
    if (m_req) begin
      if (ack) begin
        m_req = 1'b0;
        m_cnt = m_cnt + 8'd1;
      end
    end else if (pend) begin
      v = vq.pop_front();
      for (int i = 0; i < N; i++) cur[i] = v[i*8 +: 8];
      m_req = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("in_ready", 32'(bus.in_ready), 32'(m_ready()));
    chk("layer_req", 32'(bus.layer_req), 32'(m_req));
    chk("vec_count", 32'(bus.vec_count), 32'(m_cnt));
    if (bus.layer_req && !prev_req) rises++;
    prev_req = bus.layer_req;
  endtask

  task automatic idle(int n);
    bit a;
    repeat (n) step(1'b0, 8'd0, 1'b0, '0, 1'b0, a);
  endtask

  task automatic rd(logic [AW-1:0] a);
    bit x;
    step(1'b0, 8'd0, 1'b1, a, 1'b0, x);
  endtask

  task automatic ack1();
    bit x;
    step(1'b0, 8'd0, 1'b0, '0, 1'b1, x);
  endtask

  task automatic push_elem(logic [7:0] d, bit ack);
    bit acc;
    int k;
    k = 0;
    do begin
      step(1'b1, d, 1'b0, '0, ack, acc);
      k++;
    end while (!acc && k < 40);
    if (!acc) fail_now("push_timeout");
  endtask

  task automatic push_vec(logic [7:0] a, logic [7:0] b, logic [7:0] c);
    push_elem(a, 1'b0);
    push_elem(b, 1'b0);
    push_elem(c, 1'b0);
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (!m_req && k < 20) begin
      idle(1);
      k++;
    end
    if (!m_req) fail_now("wait_req");
  endtask

  task automatic do_reset_mid();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_layer_req", 32'(bus.layer_req), 32'd0);
    chk("rst_vec_count", 32'(bus.vec_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b0;
    bus.rd_trig   = 1'b0;
    bus.layer_ack = 1'b0;
    vq.delete();
    part.delete();
    exp_q.delete();
    m_req    = 1'b0;
    m_cnt    = 8'd0;
    last_rd  = 8'd0;
    prev_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // read scoreboard: pop on every rd_valid, else data must hold
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_extra: got %0h with nothing expected", bus.rd_data);
        end else begin
          chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
        end
        last_rd = bus.rd_data;
      end else begin
        chk("rd_hold", 32'(bus.rd_data), 32'(last_rd));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int k;
    int rel;
    logic [7:0] base, prev;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.rd_trig   = 1'b0;
    bus.rd_addr   = '0;
    bus.layer_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_layer_req", 32'(bus.layer_req), 32'd0);
    chk("reset_vec_count", 32'(bus.vec_count), 32'd0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset_rd_data", 32'(bus.rd_data), 32'd0);

    // read before any vector
    rd(2'd0);
    idle(1);

    // single vector and range boundary
    push_vec(8'd5, 8'hFD, 8'd9);
    wait_req();
    rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
    idle(1);

    // overlap: second vector fills, third blocked
    push_vec(8'd16, 8'hE0, 8'd7);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h11, 1'b0, '0, 1'b0, acc);
    ack1();
    wait_req();
    rd(2'd0); rd(2'd1);
    idle(1);

    // held trigger
    for (int i = 0; i < 4; i++) rd(2'd1);
    ack1();
    idle(2);

    // last accept coincides with release
    push_vec(8'd33, 8'd44, 8'd55);
    wait_req();
    push_elem(8'h81, 1'b0);
    push_elem(8'h7F, 1'b0);
    rd(2'd2);
    push_elem(8'h00, 1'b1);
    wait_req();
    rd(2'd0); rd(2'd1); rd(2'd2);
    step(1'b0, 8'd0, 1'b1, 2'd1, 1'b1, acc);
    idle(2);

    // reset in the middle of a vector
    push_elem(8'd7, 1'b0);
    do_reset_mid();
    push_vec(8'd1, 8'd2, 8'd3);
    wait_req();
    rd(2'd0); rd(2'd1); rd(2'd2);
    ack1();
    idle(2);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0),
           AW'($urandom), ($urandom_range(0, 3) == 0), acc);
    end
    k = 0;
    while ((m_req || vq.size() > 0) && k < 50) begin
      step(1'b0, 8'd0, 1'b0, '0, 1'b1, acc);
      k++;
    end
    if (m_req || vq.size() > 0) fail_now("drain");
    idle(2);

    // 256 releases with immediate ack
    base  = m_cnt;
    rises = 0;
    rel   = 0;
    k     = 0;
    while (rel < 256 && k < 4000) begin
      prev = m_cnt;
      step(1'b1, 8'($urandom), 1'b0, '0, 1'b1, acc);
      if (m_cnt != prev) rel++;
      k++;
    end
    if (rel < 256) fail_now("wrap_loop");
    chk("wrap_vec_count", 32'(bus.vec_count), 32'(base));
    chk("wrap_rises", 32'(rises), 32'd256);

    idle(3);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_input_server.md
Name: layer_input_server

Overview:
- Responder end of the layer input-read channel. A layer's MAC asserts a read trigger with an element address and captures the signed 8-bit input one cycle later; this block answers those reads.
- Holds input vectors in a two-bank (ping-pong) buffer. The upstream producer streams the next vector into one bank while the layer reads the other.
- Sits between the network's input source and layer0. It drives the layer's start request and consumes the layer's completion ack.

Parameters:
- N, 2: elements per input vector. Legal range 1..256.
- DW, 8: data width. Signed, Q4 fixed point.
- AW, 1: read address width. Must satisfy 2**AW >= N.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  producer has an element on in_data.
- in_data  in  DW  signed input element.
- in_ready  out  1  block can accept an element this cycle.
- rd_trig  in  1  layer read trigger.
- rd_addr  in  AW  element index for the read.
- rd_data  out  DW  signed read data, registered.
- rd_valid  out  1  rd_data holds the answer to the previous cycle's trigger.
- layer_req  out  1  a vector is ready for the layer; stays high until the vector is released.
- layer_ack  in  1  layer has finished with the current vector (its ack__layer).
- vec_count  out  8  number of vectors released so far; wraps modulo 256.

Behaviour:
- Reset (async assert, sync release) forces:
  - rd_data=0, rd_valid=0, layer_req=0, vec_count=0;
  - both banks EMPTY, write bank=0, serve bank=0, write index=0.
  - in_ready=1 after reset, since bank 0 is EMPTY.
- Each bank is in one of three states: EMPTY, FULL, SERVING.
- Write side:
  - in_ready=1 iff the write bank is EMPTY. Combinational from registered state.
  - An element is accepted when in_valid && in_ready. It is stored at the write index, and the index increments.
  - On accepting element N-1, the index returns to 0, the bank becomes FULL and the write bank toggles.
  - If the new write bank is not EMPTY, in_ready drops the next cycle.
- Serve state machine:
  - IDLE: when the serve bank is FULL, the bank goes to SERVING and layer_req=1 from the next cycle.
  - BUSY: layer_req is held at 1. When layer_ack is sampled 1:
    - the bank goes to EMPTY;
    - layer_req=0 on the next cycle;
    - vec_count increments;
    - the serve bank toggles;
    - the FSM returns to IDLE.
  - Minimum gap between consecutive layer_req pulses is one low cycle, so the layer sees a rising edge.
- Read side:
  - Reads are single-cycle: when rd_trig is sampled 1 at edge k, rd_data and rd_valid are updated at edge k+1.
  - rd_data = serve-bank element at rd_addr. rd_valid=1 for exactly one cycle per trigger.
  - If rd_trig is held high, one answer is produced per cycle.
  - Read is non-destructive; the layer may read any address any number of times.
  - rd_addr >= N returns 0 with rd_valid=1.
  - rd_trig while not SERVING returns 0 with rd_valid=1.
  - rd_data holds its last value when there is no trigger.
- Simultaneous events:
  - A write accept and a layer_ack in the same cycle are both applied. If the released bank is the bank the write-bank toggle points to, in_ready rises the cycle after.
  - A read trigger in the same cycle as layer_ack returns the old bank's data. The bank's contents are not cleared on release.
- layer_ack while not BUSY is ignored.
- Reset mid-operation: a partially written vector is discarded and no layer_ack is awaited.
- Arithmetic: data is stored verbatim with no saturation. Index counters wrap at N, not at 2**AW.

Decomposition:
- Shared package nn_pkg holds:
  - DW and the Q4 fractional-bit constant (4);
  - the bank-state enum {EMPTY, FULL, SERVING};
  - the serve-FSM enum {IDLE, BUSY}.
- One natural sub-module, layer_input_bank: a single N x DW register bank with write enable/index and a registered read port. It is instantiated twice; the top holds the FSM, pointers and the read mux.

Test Plan:
- Single vector: after reset, stream 5, -3 (N=2) -> in_ready high throughout; layer_req rises 2 cycles after the second accept; trigger addr 0 then 1 -> rd_data 5 then -3, each with a 1-cycle rd_valid.
- Ping-pong overlap: while vector {5,-3} is served, stream {16,-32} -> accepted. Stream a third vector -> in_ready=0. Pulse layer_ack -> layer_req falls, vec_count=1, layer_req re-rises within 2 cycles, reads return 16, -32. in_ready rises again after the release.
- Read boundaries: with N=3, AW=2, trigger addr 3 -> rd_data 0. Trigger before any layer_req -> rd_data 0, rd_valid 1. Hold rd_trig 4 cycles on addr 1 -> 4 consecutive rd_valid pulses with the same value.
- Simultaneous: assert layer_ack in the same cycle as the last element accept into the other bank -> no lost vector; vec_count increments exactly once; the next layer_req serves the newly written data.
- Reset mid-write: accept element 7 only, assert rst asynchronously mid-cycle -> outputs zero immediately. Then stream {1,2} -> reads return 1, 2, with no trace of 7.
- vec_count wrap: run 256 vectors with immediate ack -> vec_count returns to 0 and no layer_req is skipped.
